// File: rtl/ahb3_adiv5_bridge.sv
// AHB3-Lite slave to ADIv5 MEM-AP bridge.
// Each AHB transfer becomes a short sequence of AP commands (CSW, TAR, DRW)
// pushed into a command FIFO. Every command waits for its response before the
// next one is issued, so at most one command is ever in flight. CSW size and
// TAR address are cached so repeated accesses skip redundant AP writes.
module ahb3_adiv5_bridge #(
    parameter int          TAR_CACHE = 1,
    parameter logic [31:0] CSW_BASE  = 32'h2300_0000
) (
    input  logic        CLK,
    input  logic        RESETn,
    // AHB3-Lite slave
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [31:0] HRDATA,
    // ADIv5 command FIFO: {data[31:0], A[3:2], APnDP, RnW}
    output logic [35:0] ADIV5_WRDATA,
    output logic        ADIV5_WREN,
    input  logic        ADIV5_WRFULL,
    // ADIv5 response FIFO: {data[31:0], stat[2:0]}
    input  logic [34:0] ADIV5_RDDATA,
    output logic        ADIV5_RDEN,
    input  logic        ADIV5_RDEMPTY
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CSW  = 3'd1;
    localparam logic [2:0] S_TAR  = 3'd2;
    localparam logic [2:0] S_DRW  = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;
    localparam logic [2:0] S_ERR1 = 3'd6;
    localparam logic [2:0] S_ERR2 = 3'd7;

    localparam logic [2:0] STAT_OK = 3'b001;

    // Command nibbles: {A[3:2], APnDP, RnW}
    localparam logic [3:0] CMD_CSW_WR = 4'b0010;
    localparam logic [3:0] CMD_TAR_WR = 4'b0110;

    logic [2:0]  state_reg, state_next;
    logic [2:0]  cmd_kind_reg, cmd_kind_next;   // which command RESP is waiting on
    logic        rd_wait_reg, rd_wait_next;     // response popped, data valid this cycle
    logic        run_reg;                        // low during and right after reset

    logic [31:0] haddr_reg;
    logic        hwrite_reg;
    logic [1:0]  hsize_reg;
    logic        first_dp_reg;                   // first data-phase cycle
    logic [31:0] wdata_reg;

    logic        csw_valid_reg;
    logic [1:0]  csw_size_reg;
    logic        tar_valid_reg;
    logic [31:0] tar_addr_reg;

    logic [31:0] hrdata_reg;

    logic        accept;
    logic        can_accept;
    logic        take;
    logic        addr_err;
    logic        csw_need_in;
    logic        tar_need_in;
    logic        tar_need_lat;
    logic        cmd_state;
    logic        push;
    logic        pop;
    logic        sample;
    logic        resp_ok;
    logic        resp_bad;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_bits;
    logic        unused_bits;

    assign unused_bits = HTRANS[0];

    assign accept     = HSEL & HREADY & HTRANS[1];
    assign can_accept = (state_reg == S_IDLE) | (state_reg == S_DONE) | (state_reg == S_ERR2);
    assign take       = accept & can_accept;

    // Sizes above word, or addresses not aligned to the size, are rejected.
    assign addr_err = (HSIZE > 3'd2)
                    | ((HSIZE == 3'd1) & HADDR[0])
                    | ((HSIZE == 3'd2) & (HADDR[1:0] != 2'b00));

    assign csw_need_in  = !csw_valid_reg || (csw_size_reg != HSIZE[1:0]);
    assign tar_need_in  = (TAR_CACHE == 0) || !tar_valid_reg || (tar_addr_reg != HADDR);
    assign tar_need_lat = (TAR_CACHE == 0) || !tar_valid_reg || (tar_addr_reg != haddr_reg);

    assign cmd_state = (state_reg == S_CSW) | (state_reg == S_TAR) | (state_reg == S_DRW);
    assign push      = run_reg & cmd_state & !ADIV5_WRFULL;

    // Pop the awaited response in RESP; anything arriving while no command is
    // outstanding (e.g. for a command aborted by reset) is popped and dropped.
    assign pop = run_reg & !ADIV5_RDEMPTY &
                 (((state_reg == S_RESP) & !rd_wait_reg) |
                  (state_reg == S_IDLE) | (state_reg == S_DONE) |
                  (state_reg == S_ERR1) | (state_reg == S_ERR2));

    assign sample   = (state_reg == S_RESP) & rd_wait_reg;
    assign resp_ok  = sample & (ADIV5_RDDATA[2:0] == STAT_OK);
    assign resp_bad = sample & (ADIV5_RDDATA[2:0] != STAT_OK);

    // Next-state decode for the command sequencer.
    always_comb begin
        state_next    = state_reg;
        cmd_kind_next = cmd_kind_reg;
        rd_wait_next  = rd_wait_reg;
        case (state_reg)
            S_IDLE, S_DONE, S_ERR2: begin
                state_next = S_IDLE;
                if (accept) begin
                    if (addr_err)
                        state_next = S_ERR1;
                    else if (csw_need_in)
                        state_next = S_CSW;
                    else if (tar_need_in)
                        state_next = S_TAR;
                    else
                        state_next = S_DRW;
                end
            end
            S_CSW, S_TAR, S_DRW: begin
                if (push) begin
                    state_next    = S_RESP;
                    cmd_kind_next = state_reg;
                    rd_wait_next  = 1'b0;
                end
            end
            S_RESP: begin
                if (!rd_wait_reg) begin
                    if (pop)
                        rd_wait_next = 1'b1;
                end else begin
                    rd_wait_next = 1'b0;
                    if (resp_bad)
                        state_next = S_ERR1;
                    else begin
                        case (cmd_kind_reg)
                            S_CSW:   state_next = tar_need_lat ? S_TAR : S_DRW;
                            S_TAR:   state_next = S_DRW;
                            default: state_next = S_DONE;
                        endcase
                    end
                end
            end
            S_ERR1:  state_next = S_ERR2;
            default: state_next = S_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_reg    <= S_IDLE;
            cmd_kind_reg <= S_IDLE;
            rd_wait_reg  <= 1'b0;
            run_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cmd_kind_reg <= cmd_kind_next;
            rd_wait_reg  <= rd_wait_next;
            run_reg      <= 1'b1;
        end
    end

    // Address-phase capture and write data taken in the first data-phase cycle.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            haddr_reg    <= 32'h0;
            hwrite_reg   <= 1'b0;
            hsize_reg    <= 2'b00;
            first_dp_reg <= 1'b0;
            wdata_reg    <= 32'h0;
        end else begin
            if (take) begin
                haddr_reg  <= HADDR;
                hwrite_reg <= HWRITE;
                hsize_reg  <= HSIZE[1:0];
            end
            first_dp_reg <= take;
            if (first_dp_reg)
                wdata_reg <= HWDATA;
        end
    end

    // CSW/TAR caches; TAR never auto-increments, so a DRW leaves TAR at haddr.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            csw_valid_reg <= 1'b0;
            csw_size_reg  <= 2'b00;
            tar_valid_reg <= 1'b0;
            tar_addr_reg  <= 32'h0;
        end else if (resp_bad) begin
            csw_valid_reg <= 1'b0;
            tar_valid_reg <= 1'b0;
        end else if (resp_ok) begin
            if (cmd_kind_reg == S_CSW) begin
                csw_valid_reg <= 1'b1;
                csw_size_reg  <= hsize_reg;
            end else begin
                tar_valid_reg <= 1'b1;
                tar_addr_reg  <= haddr_reg;
            end
        end
    end

    // Read data register, loaded only by a successful DRW read.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn)
            hrdata_reg <= 32'h0;
        else if (resp_ok && (cmd_kind_reg == S_DRW) && !hwrite_reg)
            hrdata_reg <= ADIV5_RDDATA[34:3];
    end

    // Command word for the current issuing state.
    always_comb begin
        cmd_data = 32'h0;
        cmd_bits = 4'b0000;
        case (state_reg)
            S_CSW: begin
                cmd_data = CSW_BASE | {30'b0, hsize_reg};
                cmd_bits = CMD_CSW_WR;
            end
            S_TAR: begin
                cmd_data = haddr_reg;
                cmd_bits = CMD_TAR_WR;
            end
            S_DRW: begin
                if (hwrite_reg)
                    cmd_data = first_dp_reg ? HWDATA : wdata_reg;
                cmd_bits = {2'b11, 1'b1, !hwrite_reg};
            end
            default: begin
                cmd_data = 32'h0;
                cmd_bits = 4'b0000;
            end
        endcase
    end

    assign ADIV5_WRDATA = (run_reg & cmd_state) ? {cmd_data, cmd_bits} : 36'h0;
    assign ADIV5_WREN   = push;
    assign ADIV5_RDEN   = pop;

    assign HREADYOUT = can_accept;
    assign HRESP     = (state_reg == S_ERR1) | (state_reg == S_ERR2);
    assign HRDATA    = hrdata_reg;

endmodule

// File: tb/tb_ahb3_adiv5_bridge.sv
// Scoreboard bench for ahb3_adiv5_bridge: expected ADIv5 commands and AHB
// results are queued as stimulus is driven and checked as the DUT produces them.
module tb_ahb3_adiv5_bridge;

    logic        CLK;
    logic        RESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic        HWRITE;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [35:0] ADIV5_WRDATA;
    logic        ADIV5_WREN;
    logic        ADIV5_WRFULL;
    logic [34:0] ADIV5_RDDATA;
    logic        ADIV5_RDEN;
    logic        ADIV5_RDEMPTY;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [35:0] word;
        logic [35:0] mask;
    } cmd_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } ahb_t;

    cmd_t cmd_q[$];
    ahb_t ahb_q[$];

    // Response stub state
    logic        resp_valid = 1'b0;
    logic [34:0] resp_word  = 35'h0;
    logic        err_on_tar = 1'b0;
    logic [31:0] stub_rdata = 32'h0;
    int          inj_cnt    = 0;
    int          inj_done   = 0;

    logic [31:0] last_rd;

    ahb3_adiv5_bridge dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .HSEL          (HSEL),
        .HADDR         (HADDR),
        .HWRITE        (HWRITE),
        .HTRANS        (HTRANS),
        .HSIZE         (HSIZE),
        .HWDATA        (HWDATA),
        .HREADY        (HREADY),
        .HREADYOUT     (HREADYOUT),
        .HRESP         (HRESP),
        .HRDATA        (HRDATA),
        .ADIV5_WRDATA  (ADIV5_WRDATA),
        .ADIV5_WREN    (ADIV5_WREN),
        .ADIV5_WRFULL  (ADIV5_WRFULL),
        .ADIV5_RDDATA  (ADIV5_RDDATA),
        .ADIV5_RDEN    (ADIV5_RDEN),
        .ADIV5_RDEMPTY (ADIV5_RDEMPTY)
    );

    // Single slave on the bus: ready loops back
    assign HREADY        = HREADYOUT;
    assign ADIV5_RDEMPTY = !resp_valid;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_cmd(input logic [31:0] data, input logic [3:0] bits, input logic [35:0] mask);
        cmd_t c;
        c.word = {data, bits};
        c.mask = mask;
        cmd_q.push_back(c);
    endtask

    // Response FIFO stub: one slot, answers the cycle after a push
    always @(posedge CLK) begin
        if (ADIV5_RDEN) begin
            ADIV5_RDDATA <= resp_word;
            resp_valid   <= 1'b0;
        end
        if (ADIV5_WREN) begin
            resp_valid <= 1'b1;
            if (err_on_tar && ADIV5_WRDATA[3:0] == 4'b0110)
                resp_word <= {ADIV5_WRDATA[35:4], 3'b010};
            else if (ADIV5_WRDATA[0])
                resp_word <= {stub_rdata, 3'b001};
            else
                resp_word <= {32'h0, 3'b001};
        end else if (inj_cnt != inj_done) begin
            resp_valid <= 1'b1;
            resp_word  <= {32'hBAD0_BAD0, 3'b001};
            inj_done   <= inj_done + 1;
        end
    end

    // Command monitor, sampled mid-cycle
    always @(negedge CLK) begin
        if (RESETn && ADIV5_WRFULL)
            check("wren_while_full", ADIV5_WREN, 1'b0);
        if (RESETn && ADIV5_WREN) begin
            if (cmd_q.size() == 0)
                check("unexpected_cmd", ADIV5_WRDATA, 36'h0);
            else begin
                cmd_t e;
                e = cmd_q.pop_front();
                check("cmd", ADIV5_WRDATA & e.mask, e.word & e.mask);
            end
        end
    end

    task automatic ahb_xfer(input string tag, input logic [31:0] addr, input logic wr,
                            input logic [2:0] size, input logic [31:0] wdata,
                            input logic exp_err, input logic [31:0] exp_rdata,
                            input int exp_cycles);
        ahb_t e;
        int   cycles;
        logic done;
        logic prev_resp;
        e.err   = exp_err;
        e.rdata = exp_rdata;
        ahb_q.push_back(e);
        @(posedge CLK); #1;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = size;
        @(posedge CLK); #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = wdata;
        cycles    = 0;
        done      = 1'b0;
        prev_resp = 1'b0;
        while (!done && cycles < 200) begin
            @(negedge CLK);
            cycles++;
            if (HREADYOUT)
                done = 1'b1;
            else
                prev_resp = HRESP;
        end
        check({tag, "_done"}, done, 1'b1);
        e = ahb_q.pop_front();
        if (done) begin
            check({tag, "_hresp"}, HRESP, e.err);
            if (e.err)
                check({tag, "_err_cycle1"}, prev_resp, 1'b1);
            check({tag, "_hrdata"}, HRDATA, e.rdata);
            if (exp_cycles > 0)
                check({tag, "_latency"}, cycles, exp_cycles);
        end
        check({tag, "_cmds_left"}, cmd_q.size(), 0);
        $display("XFER %s addr=%08h wr=%0d size=%0d hresp=%0d hrdata=%08h cycles=%0d",
                 tag, addr, wr, size, HRESP, HRDATA, cycles);
    endtask

    initial begin
        RESETn       = 1'b0;
        HSEL         = 1'b0;
        HADDR        = 32'h0;
        HWRITE       = 1'b0;
        HTRANS       = 2'b00;
        HSIZE        = 3'd0;
        HWDATA       = 32'h0;
        ADIV5_WRFULL = 1'b0;
        last_rd      = 32'h0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_hreadyout", HREADYOUT, 1'b1);
        check("rst_hresp", HRESP, 1'b0);
        check("rst_hrdata", HRDATA, 32'h0);
        check("rst_wren", ADIV5_WREN, 1'b0);
        check("rst_rden", ADIV5_RDEN, 1'b0);
        check("rst_wrdata", ADIV5_WRDATA, 36'h0);
        RESETn = 1'b1;

        // Cold read: CSW, TAR, DRW read
        stub_rdata = 32'hDEAD_BEEF;
        push_cmd(32'h2300_0002, 4'b0010, '1);
        push_cmd(32'h2000_0000, 4'b0110, '1);
        push_cmd(32'h0, 4'b1111, 36'hF);
        last_rd = 32'hDEAD_BEEF;
        ahb_xfer("rd_cold", 32'h2000_0000, 1'b0, 3'd2, 32'h0, 1'b0, last_rd, 10);

        // Repeat write, both caches hit: DRW write only (A=0xC, AP, write)
        push_cmd(32'h1234_5678, 4'b1110, '1);
        ahb_xfer("wr_hit", 32'h2000_0000, 1'b1, 3'd2, 32'h1234_5678, 1'b0, last_rd, 4);

        // Repeat read, cache hit
        stub_rdata = 32'hCAFE_F00D;
        push_cmd(32'h0, 4'b1111, 36'hF);
        last_rd = 32'hCAFE_F00D;
        ahb_xfer("rd_hit", 32'h2000_0000, 1'b0, 3'd2, 32'h0, 1'b0, last_rd, 4);

        // Halfword read: new size and new address
        stub_rdata = 32'hA5A5_1234;
        push_cmd(32'h2300_0001, 4'b0010, '1);
        push_cmd(32'h2000_0002, 4'b0110, '1);
        push_cmd(32'h0, 4'b1111, 36'hF);
        last_rd = 32'hA5A5_1234;
        ahb_xfer("rd_half", 32'h2000_0002, 1'b0, 3'd1, 32'h0, 1'b0, last_rd, 10);

        // Misaligned word and oversized transfers: no commands, two-cycle error
        ahb_xfer("rd_misalign", 32'h2000_0001, 1'b0, 3'd2, 32'h0, 1'b1, last_rd, 2);
        ahb_xfer("rd_size3", 32'h2000_0008, 1'b0, 3'd3, 32'h0, 1'b1, last_rd, 2);

        // TAR write answered with a fault: error, no DRW, caches dropped
        err_on_tar = 1'b1;
        push_cmd(32'h2300_0002, 4'b0010, '1);
        push_cmd(32'h3000_0000, 4'b0110, '1);
        ahb_xfer("rd_tar_fault", 32'h3000_0000, 1'b0, 3'd2, 32'h0, 1'b1, last_rd, 0);
        err_on_tar = 1'b0;

        stub_rdata = 32'h0BAD_CAFE;
        push_cmd(32'h2300_0002, 4'b0010, '1);
        push_cmd(32'h3000_0000, 4'b0110, '1);
        push_cmd(32'h0, 4'b1111, 36'hF);
        last_rd = 32'h0BAD_CAFE;
        ahb_xfer("rd_retry", 32'h3000_0000, 1'b0, 3'd2, 32'h0, 1'b0, last_rd, 10);

        // Write stalled by a full command FIFO, then reset during the stall
        @(posedge CLK); #1;
        ADIV5_WRFULL = 1'b1;
        HSEL   = 1'b1;
        HTRANS = 2'b10;
        HADDR  = 32'h3000_0000;
        HWRITE = 1'b1;
        HSIZE  = 3'd2;
        @(posedge CLK); #1;
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        HWDATA = 32'h5555_AAAA;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check("full_stall_hreadyout", HREADYOUT, 1'b0);
        end
        @(posedge CLK); #1;
        RESETn = 1'b0;
        #1;
        check("abort_hreadyout", HREADYOUT, 1'b1);
        check("abort_hresp", HRESP, 1'b0);
        check("abort_hrdata", HRDATA, 32'h0);
        check("abort_wren", ADIV5_WREN, 1'b0);
        check("abort_rden", ADIV5_RDEN, 1'b0);
        check("abort_wrdata", ADIV5_WRDATA, 36'h0);
        $display("XFER abort_during_full addr=30000000 wr=1 reset applied");
        repeat (2) @(posedge CLK);
        #1;
        ADIV5_WRFULL = 1'b0;
        RESETn       = 1'b1;
        last_rd      = 32'h0;

        // Caches cleared by reset: full sequence again
        stub_rdata = 32'h1357_9BDF;
        push_cmd(32'h2300_0002, 4'b0010, '1);
        push_cmd(32'h3000_0000, 4'b0110, '1);
        push_cmd(32'h0, 4'b1111, 36'hF);
        last_rd = 32'h1357_9BDF;
        ahb_xfer("rd_after_rst", 32'h3000_0000, 1'b0, 3'd2, 32'h0, 1'b0, last_rd, 10);

        // Spurious response while idle is popped and dropped
        @(posedge CLK); #1;
        inj_cnt = inj_cnt + 1;
        repeat (4) @(negedge CLK);
        check("spurious_drained", resp_valid, 1'b0);
        check("spurious_hrdata", HRDATA, last_rd);
        $display("XFER spurious_resp drained=%0d", !resp_valid);

        stub_rdata = 32'h2468_ACE0;
        push_cmd(32'h0, 4'b1111, 36'hF);
        last_rd = 32'h2468_ACE0;
        ahb_xfer("rd_post_spur", 32'h3000_0000, 1'b0, 3'd2, 32'h0, 1'b0, last_rd, 4);

        repeat (3) @(posedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
